// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time,
// and hands each fetched word to decode over a valid/ready handshake.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_fetch_count;

  logic [31:0] w_target;
  logic        w_unused;

  assign w_target = {branch_target[31:2], 2'b00};
  assign w_unused = ^branch_target[1:0];

  assign imem_req    = (r_state == S_REQ) && !reset;
  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'h0000_0013;
      r_if_pc       <= 32'h0;
      r_fetch_count <= 32'h0;
    end else if (branch_taken) begin
      // Redirect wins; any request still outstanding must be drained.
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
      unique case (r_state)
        S_REQ:   r_state <= S_DRAIN;
        S_WAIT:  r_state <= imem_rvalid ? S_REQ : S_DRAIN;
        S_HOLD:  r_state <= S_REQ;
        S_DRAIN: r_state <= imem_rvalid ? S_REQ : S_DRAIN;
        default: r_state <= S_REQ;
      endcase
    end else begin
      unique case (r_state)
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            r_if_instr <= imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 32'd4;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            r_if_valid    <= 1'b0;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small latency-configurable
// memory model; a second instance checks PC wrap from the top of memory.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] fetch_count;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  int due    = 0;
  bit pend   = 1'b0;
  logic [31:0] req_addr;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc),
    .id_ready(id_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_count(w_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Memory answers with 0x00500093 + address, lat cycles after the request.
  task automatic note_req();
    if (imem_req) begin
      pend     = 1'b1;
      due      = cyc + lat;
      req_addr = imem_addr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      pend        = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = pend && (cyc == due);
      imem_rdata  = 32'h0050_0093 + req_addr;
      if (imem_rvalid) pend = 1'b0;
      note_req();
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
    cyc = 0;
    note_req();
  endtask

  initial begin
    reset         = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    id_ready      = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    req_addr      = 32'h0;
    lat           = 1;
    tick();
    tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0000_0013);
    check("rst_pc", if_pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);

    release_reset();
    check("c0_req", {31'd0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_waddr", w_addr, 32'hFFFF_FFFC);
    tick();
    check("c1_valid", {31'd0, if_valid}, 32'd0);
    check("c1_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("c2_valid", {31'd0, if_valid}, 32'd1);
    check("c2_pc", if_pc, 32'h0);
    check("c2_instr", if_instr, 32'h0050_0093);
    check("c2_wpc", w_pc, 32'hFFFF_FFFC);
    tick();
    check("c3_addr", imem_addr, 32'h4);
    check("c3_req", {31'd0, imem_req}, 32'd1);
    check("c3_count", fetch_count, 32'd1);
    check("c3_valid", {31'd0, if_valid}, 32'd0);
    check("wrap_addr", w_addr, 32'h0);

    // Backpressure: five cycles in HOLD with decode stalled.
    id_ready = 1'b0;
    tick();
    tick();
    check("bp_valid", {31'd0, if_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_instr", if_instr, 32'h0050_0097);
      check("bp_pc", if_pc, 32'h4);
      check("bp_req", {31'd0, imem_req}, 32'd0);
      check("bp_count", fetch_count, 32'd1);
      if (i < 4) tick();
    end
    id_ready = 1'b1;
    lat      = 3;
    tick();
    check("bp_done_cnt", fetch_count, 32'd2);
    check("bp_done_addr", imem_addr, 32'h8);

    // Redirect while waiting on a 3-cycle response.
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    check("dr_req", {31'd0, imem_req}, 32'd0);
    check("dr_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    check("dr_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("dr_valid1", {31'd0, if_valid}, 32'd0);
    tick();
    check("dr_valid2", {31'd0, if_valid}, 32'd0);
    check("dr_req2", {31'd0, imem_req}, 32'd1);
    check("dr_addr", imem_addr, 32'h100);
    tick();
    tick();
    tick();
    tick();
    check("tgt_valid", {31'd0, if_valid}, 32'd1);
    check("tgt_pc", if_pc, 32'h100);
    check("tgt_instr", if_instr, 32'h0050_0193);

    // Redirect together with a handshake in HOLD.
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    lat           = 1;
    tick();
    branch_taken = 1'b0;
    check("hb_valid", {31'd0, if_valid}, 32'd0);
    check("hb_count", fetch_count, 32'd2);
    check("hb_req", {31'd0, imem_req}, 32'd1);
    check("hb_addr", imem_addr, 32'h200);

    // Redirect coinciding with the response in WAIT: no drain.
    tick();
    check("wb_rvalid", {31'd0, imem_rvalid}, 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    tick();
    branch_taken = 1'b0;
    check("wb_req", {31'd0, imem_req}, 32'd1);
    check("wb_addr", imem_addr, 32'h300);
    check("wb_valid", {31'd0, if_valid}, 32'd0);
    tick();
    lat = 3;
    tick();
    check("wb_pc", if_pc, 32'h300);
    check("wb_instr", if_instr, 32'h0050_0393);
    tick();
    check("wb_count", fetch_count, 32'd3);
    check("wb_next", imem_addr, 32'h304);

    // Reset asserted while waiting on memory.
    tick();
    check("rw_state_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    tick();
    check("rw_valid", {31'd0, if_valid}, 32'd0);
    check("rw_req", {31'd0, imem_req}, 32'd0);
    check("rw_count", fetch_count, 32'd0);
    check("rw_instr", if_instr, 32'h0000_0013);
    release_reset();
    check("rw_addr", imem_addr, 32'h0);
    check("rw_req1", {31'd0, imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
